// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, instruction field positions, opcodes and sequencer states.
package cpu_pkg;
  localparam int DW = 15;
  localparam int AW = 3;
  localparam int NREGS = 7;
  localparam int OP_LSB = 12;
  localparam int RD_LSB = 9;
  localparam int RS1_LSB = 6;
  localparam int RS2_LSB = 3;
  localparam int IMM_W = 9;
  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_LDI = 3'd7;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;
  function automatic logic reg_ok(input logic [AW-1:0] a);
    return int'(a) < NREGS;
  endfunction
endpackage

// File: rtl/exec_alu.sv
// exec_alu: combinational ALU; carry is the ADD carry-out or the SUB borrow.
module exec_alu
  import cpu_pkg::*;
(
  input  logic [2:0]       op_i,
  input  logic [DW-1:0]    op1_i,
  input  logic [DW-1:0]    op2_i,
  input  logic [IMM_W-1:0] imm9_i,
  output logic [DW-1:0]    result_o,
  output logic             carry_o
);
  logic [DW:0] sum, diff;
  logic [3:0]  sh;
  assign sum  = {1'b0, op1_i} + {1'b0, op2_i};
  assign diff = {1'b0, op1_i} - {1'b0, op2_i};
  assign sh   = op2_i[3:0];
  always_comb begin
    result_o = '0;
    carry_o  = 1'b0;
    case (op_i)
      OP_ADD:  {carry_o, result_o} = sum;
      OP_SUB:  {carry_o, result_o} = diff;
      OP_AND:  result_o = op1_i & op2_i;
      OP_OR:   result_o = op1_i | op2_i;
      OP_XOR:  result_o = op1_i ^ op2_i;
      OP_SHL:  result_o = (sh == 4'd15) ? '0 : op1_i << sh;
      OP_LDI:  result_o = DW'(imm9_i);
      default: result_o = '0;
    endcase
  end
endmodule

// File: rtl/regfile_exec_stage.sv
// regfile_exec_stage: 4-cycle read/exec/writeback sequencer around a 7x15 register file.
// Define EXEC_FLAGS_EN to register zero/carry flags; otherwise they are tied low.
module regfile_exec_stage
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [DW-1:0] instr,
  output logic [AW-1:0] ra1,
  output logic [AW-1:0] ra2,
  input  logic [DW-1:0] rd1,
  input  logic [DW-1:0] rd2,
  output logic [AW-1:0] wa,
  output logic [DW-1:0] wd,
  output logic          we,
  output logic          done,
  output logic          err,
  output logic          flag_z,
  output logic          flag_c
);
  state_t state_q, state_d;
  logic [DW-1:0] instr_q, instr_d, op1_q, op1_d, op2_q, op2_d, wd_q, wd_d;
  logic [AW-1:0] ra1_q, ra1_d, ra2_q, ra2_d, wa_q, wa_d;
  logic we_q, we_d, done_q, done_d, err_q, err_d;
  logic [2:0] op;
  logic [AW-1:0] rd_a;
  logic rd_ok;
  logic [DW-1:0] alu_res;
  assign op    = instr_q[OP_LSB +: 3];
  assign rd_a  = instr_q[RD_LSB +: AW];
  assign rd_ok = reg_ok(rd_a);
  assign instr_ready = state_q == S_IDLE;
  assign {ra1, ra2, wa, wd} = {ra1_q, ra2_q, wa_q, wd_q};
  assign {we, done, err} = {we_q, done_q, err_q};
`ifdef EXEC_FLAGS_EN
  logic alu_c, flag_z_q, flag_c_q;
`endif
  exec_alu u_alu (
    .op_i    (op),
    .op1_i   (op1_q),
    .op2_i   (op2_q),
    .imm9_i  (instr_q[IMM_W-1:0]),
    .result_o(alu_res),
`ifdef EXEC_FLAGS_EN
    .carry_o (alu_c)
`else
    .carry_o ()
`endif
  );
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    ra1_d   = ra1_q;
    ra2_d   = ra2_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: if (instr_valid) begin
        state_d = S_READ;
        instr_d = instr;
        ra1_d   = instr[RS1_LSB +: AW];
        ra2_d   = instr[RS2_LSB +: AW];
      end
      // Index 7 is not a real register, so its operand reads as zero.
      S_READ: begin
        state_d = S_EXEC;
        op1_d   = reg_ok(ra1_q) ? rd1 : '0;
        op2_d   = reg_ok(ra2_q) ? rd2 : '0;
      end
      S_EXEC: begin
        state_d = S_WB;
        wa_d    = rd_a;
        wd_d    = alu_res;
        we_d    = rd_ok && op != OP_NOP;
        done_d  = 1'b1;
        err_d   = !rd_ok;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      ra1_q   <= '0;
      ra2_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      wa_q    <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      ra1_q   <= ra1_d;
      ra2_q   <= ra2_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
`ifdef EXEC_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else if (state_q == S_EXEC && rd_ok && op != OP_NOP) begin
      flag_z_q <= alu_res == '0;
      flag_c_q <= alu_c;
    end
  end
  assign flag_z = flag_z_q;
  assign flag_c = flag_c_q;
`else
  assign flag_z = 1'b0;
  assign flag_c = 1'b0;
`endif
endmodule

// File: tb/tb_regfile_exec_stage.sv
// tb_regfile_exec_stage: directed vectors with a queue scoreboard checked by a done-driven monitor.
module tb_regfile_exec_stage;
  import cpu_pkg::*;
`ifdef EXEC_FLAGS_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif
  typedef struct packed {
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          we, err, z, c;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0, instr_valid = 1'b0;
  logic [DW-1:0] instr = '0;
  logic instr_ready, we, done, err, flag_z, flag_c;
  logic [AW-1:0] ra1, ra2, wa;
  logic [DW-1:0] rd1, rd2, wd;
  logic [DW-1:0] rf [NREGS];
  exp_t sb[$];
  int total = 0, bad = 0;

  regfile_exec_stage dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .wa(wa), .wd(wd),
    .we(we), .done(done), .err(err), .flag_z(flag_z), .flag_c(flag_c)
  );

  always #5 clk = ~clk;

  // Address 7 returns junk so the bench sees whether the stage zeroes it.
  function automatic logic [DW-1:0] rf_rd(input logic [AW-1:0] a);
    return (int'(a) < NREGS) ? rf[a] : 15'h2A5A;
  endfunction
  assign rd1 = rf_rd(ra1);
  assign rd2 = rf_rd(ra2);
  always @(posedge clk) if (we && int'(wa) < NREGS) rf[wa] <= wd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    total++;
    if (act !== ex) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, ex);
    end
  endtask

  function automatic logic [DW-1:0] enc(input logic [2:0] op, input int rd, rs1, rs2);
    return {op, 3'(rd), 3'(rs1), 3'(rs2), 3'b000};
  endfunction
  function automatic logic [DW-1:0] ldi(input int rd, input int imm);
    return {OP_LDI, 3'(rd), 9'(imm)};
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      chk("we_without_done", {31'b0, we && !done}, 0);
      if (done) begin
        if (sb.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = sb.pop_front();
          chk("wa", wa, e.wa);
          if (e.we) chk("wd", wd, e.wd);
          chk("we", we, e.we);
          chk("err", err, e.err);
          chk("flag_z", flag_z, e.z);
          chk("flag_c", flag_c, e.c);
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!instr_ready && n < 20) begin n++; @(negedge clk); end
    chk("ready_before_issue", instr_ready, 1);
  endtask

  task automatic issue(input logic [DW-1:0] ins, input int ewa, input logic [DW-1:0] ewd,
                       input logic ewe, eerr, ez, ec);
    int n;
    wait_ready();
    instr = ins;
    instr_valid = 1'b1;
    sb.push_back('{AW'(ewa), ewd, ewe, eerr, FE & ez, FE & ec});
    @(negedge clk);
    instr_valid = 1'b0;
    instr = ~ins;
    n = 0;
    while (!instr_ready && n < 10) begin n++; @(negedge clk); end
    chk("ready_low_cycles", n, 3);
  endtask

  initial begin
    int n, acc, first, last, n_act;
    for (int i = 0; i < NREGS; i++) rf[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", instr_ready, 1);
    chk("rst_we", we, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_wa", wa, 0);
    chk("rst_wd", wd, 0);
    chk("rst_ra", {ra1, ra2}, 0);
    chk("rst_flags", {flag_z, flag_c}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    issue(ldi(1, 5),              1, 15'h0005, 1, 0, 0, 0);
    issue(ldi(2, 7),              2, 15'h0007, 1, 0, 0, 0);
    issue(enc(OP_ADD, 3, 1, 2),   3, 15'h000C, 1, 0, 0, 0);
    issue(ldi(6, 1),              6, 15'h0001, 1, 0, 0, 0);
    issue(enc(OP_SUB, 1, 0, 6),   1, 15'h7FFF, 1, 0, 0, 1);
    issue(enc(OP_ADD, 4, 1, 1),   4, 15'h7FFE, 1, 0, 0, 1);
    issue(enc(OP_SUB, 5, 2, 2),   5, 15'h0000, 1, 0, 1, 0);
    issue(enc(OP_ADD, 7, 1, 2),   7, 15'h0006, 0, 1, 1, 0);
    issue(enc(OP_ADD, 1, 7, 2),   1, 15'h0007, 1, 0, 0, 0);
    issue(enc(OP_NOP, 0, 0, 0),   0, 15'h0000, 0, 0, 0, 0);
    issue(enc(OP_AND, 3, 3, 4),   3, 15'h000C, 1, 0, 0, 0);
    issue(enc(OP_OR,  5, 1, 3),   5, 15'h000F, 1, 0, 0, 0);
    issue(enc(OP_XOR, 5, 5, 5),   5, 15'h0000, 1, 0, 1, 0);
    issue(ldi(4, 14),             4, 15'h000E, 1, 0, 0, 0);
    issue(enc(OP_SHL, 5, 6, 4),   5, 15'h4000, 1, 0, 0, 0);
    issue(enc(OP_ADD, 5, 5, 6),   5, 15'h4001, 1, 0, 0, 0);
    issue(enc(OP_SHL, 5, 5, 6),   5, 15'h0002, 1, 0, 0, 0);
    issue(ldi(4, 15),             4, 15'h000F, 1, 0, 0, 0);
    issue(enc(OP_SHL, 3, 1, 4),   3, 15'h0000, 1, 0, 1, 0);
    issue(enc(OP_SUB, 2, 6, 2),   2, 15'h7FFA, 1, 0, 0, 1);
    issue(ldi(2, 9'h1FF),         2, 15'h01FF, 1, 0, 0, 0);
    issue(enc(OP_SUB, 5, 6, 6),   5, 15'h0000, 1, 0, 1, 0);
    // Abandon an instruction mid-EXEC; nothing may be written or retired.
    wait_ready();
    instr = enc(OP_ADD, 3, 1, 2);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", instr_ready, 1);
    chk("midrst_we", we, 0);
    chk("midrst_wa", wa, 0);
    chk("midrst_wd", wd, 0);
    chk("midrst_flags", {flag_z, flag_c}, 0);
    n_act = 0;
    repeat (2) begin @(negedge clk); n_act += int'(we) + int'(done); end
    rst_n = 1'b1;
    repeat (6) begin @(negedge clk); n_act += int'(we) + int'(done); end
    chk("midrst_no_activity", n_act, 0);
    chk("midrst_idle_ready", instr_ready, 1);
    // Valid held high: one accept every fourth cycle.
    wait_ready();
    repeat (4) sb.push_back('{AW'(6), 15'h0001, 1'b1, 1'b0, 1'b0, 1'b0});
    instr = ldi(6, 1);
    instr_valid = 1'b1;
    acc = 0; first = -1; last = -1;
    for (int i = 0; i < 16; i++) begin
      if (instr_ready) begin acc++; if (first < 0) first = i; last = i; end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    chk("held_accepts", acc, 4);
    chk("held_span", last - first, 12);
    issue(enc(OP_ADD, 3, 6, 2),   3, 15'h0200, 1, 0, 0, 0);
    n = 0;
    while (sb.size() != 0 && n < 20) begin n++; @(negedge clk); end
    chk("drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
